bcd_digit_formatter: RTL and testbench

BCD_DIGIT_FORMATTER -- requirements
Module: bcd_digit_formatter

---
 rtl/bcd_digit_formatter.sv | 127 ++++++++++++
 tb/tb_bcd_digit_formatter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_formatter.sv
// Serial binary-to-BCD formatter for a four-digit 7-segment display.
// One double-dabble step per cycle; digits, enables and OVF update together on LOAD exit.

module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_digit_formatter #(
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [13:0] VALUE,
   output logic        BUSY,
   output logic        DONE,
   output logic        OVF,
   output logic [3:0]  NUM0,
   output logic [3:0]  NUM1,
   output logic [3:0]  NUM2,
   output logic [3:0]  NUM3,
   output logic        EN0,
   output logic        EN1,
   output logic        EN2,
   output logic        EN3
);
   typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

   state_t           state, state_nxt;
   logic [13:0]      sh;
   logic [15:0]      bcd;
   logic [3:0][3:0]  bcd_adj;
   logic [16:0]      shifted;
   logic [3:0]       cnt;
   logic             ovf_pend;
   logic [3:0][3:0]  num_q;
   logic [3:0]       en_q;
   logic [3:0]       nz;
   logic [3:0]       en_calc;

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_nib
         bcd_add3 u_add3 (.d(bcd[g*4 +: 4]), .q(bcd_adj[g]));
      end
   endgenerate

   assign shifted = {bcd_adj, sh[13]};

   // Leading-zero blanking: a digit lights if it or any higher digit is nonzero.
   always_comb begin
      nz = {|bcd[15:12], |bcd[11:8], |bcd[7:4], |bcd[3:0]};
      en_calc = {nz[3], |nz[3:2], |nz[3:1], 1'b1};
      if (!LZ_BLANK) en_calc = 4'b1111;
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = CONVERT;
         CONVERT: if (cnt == 4'd13) state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sh       <= '0;
         bcd      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         num_q    <= '0;
         en_q     <= '0;
         OVF      <= 1'b0;
         DONE     <= 1'b0;
      end else begin
         DONE <= (state == LOAD);
         case (state)
            IDLE: if (START) begin
               sh       <= VALUE;
               bcd      <= '0;
               cnt      <= '0;
               ovf_pend <= (VALUE > 14'd9999);
            end
            CONVERT: begin
               bcd <= shifted[15:0];
               sh  <= {sh[12:0], 1'b0};
               cnt <= cnt + 4'd1;
               // A carry out of the thousands nibble can only occur for
               // values already flagged as overflow; keep it sticky anyway.
               ovf_pend <= ovf_pend | shifted[16];
            end
            LOAD: begin
               if (ovf_pend) begin
                  num_q <= {4'hE, 4'h0, 4'h0, 4'h0};
                  en_q  <= 4'b1000;
                  OVF   <= 1'b1;
               end else begin
                  num_q <= bcd;
                  en_q  <= en_calc;
                  OVF   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign BUSY = (state != IDLE);
   assign NUM0 = num_q[0];
   assign NUM1 = num_q[1];
   assign NUM2 = num_q[2];
   assign NUM3 = num_q[3];
   assign EN0  = en_q[0];
   assign EN1  = en_q[1];
   assign EN2  = en_q[2];
   assign EN3  = en_q[3];
endmodule

// File: tb/tb_bcd_digit_formatter.sv
// Directed bench for bcd_digit_formatter: one blanking and one non-blanking instance.

module tb_bcd_digit_formatter;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        START = 1'b0;
   logic [13:0] VALUE = '0;

   logic       busy, done, ovf, en0, en1, en2, en3;
   logic [3:0] num0, num1, num2, num3;
   logic       b_busy, b_done, b_ovf, b_en0, b_en1, b_en2, b_en3;
   logic [3:0] b_num0, b_num1, b_num2, b_num3;

   int checks = 0;
   int errors = 0;

   wire [15:0] nums   = {num3, num2, num1, num0};
   wire [3:0]  ens    = {en3, en2, en1, en0};
   wire [15:0] nums_b = {b_num3, b_num2, b_num1, b_num0};
   wire [3:0]  ens_b  = {b_en3, b_en2, b_en1, b_en0};

   bcd_digit_formatter #(.LZ_BLANK(1'b1)) dut (
      .CLK(CLK), .RST(RST), .START(START), .VALUE(VALUE),
      .BUSY(busy), .DONE(done), .OVF(ovf),
      .NUM0(num0), .NUM1(num1), .NUM2(num2), .NUM3(num3),
      .EN0(en0), .EN1(en1), .EN2(en2), .EN3(en3)
   );

   bcd_digit_formatter #(.LZ_BLANK(1'b0)) dut_nb (
      .CLK(CLK), .RST(RST), .START(START), .VALUE(VALUE),
      .BUSY(b_busy), .DONE(b_done), .OVF(b_ovf),
      .NUM0(b_num0), .NUM1(b_num1), .NUM2(b_num2), .NUM3(b_num3),
      .EN0(b_en0), .EN1(b_en1), .EN2(b_en2), .EN3(b_en3)
   );

   always #5 CLK = ~CLK;

   task automatic do_start(input logic [13:0] v);
      @(negedge CLK);
      START = 1'b1;
      VALUE = v;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   // Cycles from the accepting edge to the first DONE observation, -1 on timeout.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         @(posedge CLK);
         #1;
         if (done) n = i;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      START = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      checks++; if (nums !== 16'h0000) begin errors++; $display("FAIL reset_num got %h exp 0000", nums); end
      checks++; if (ens !== 4'b0000) begin errors++; $display("FAIL reset_en got %b exp 0000", ens); end
      checks++; if (ens_b !== 4'b0000) begin errors++; $display("FAIL reset_en_nb got %b exp 0000", ens_b); end
   endtask

   task automatic test_basic();
      int bad_busy, bad_hold;
      bad_busy = 0;
      bad_hold = 0;
      do_start(14'd1234);
      for (int i = 1; i <= 14; i++) begin
         @(posedge CLK);
         #1;
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
         if (nums !== 16'h0000 || ens !== 4'b0000) bad_hold++;
      end
      checks++; if (bad_busy != 0) begin errors++; $display("FAIL basic_busy_window got %0d bad cycles exp 0", bad_busy); end
      checks++; if (bad_hold != 0) begin errors++; $display("FAIL basic_hold_during_convert got %0d bad cycles exp 0", bad_hold); end
      @(posedge CLK);
      #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_k15 got %b exp 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", busy); end
      checks++; if (nums !== 16'h1234) begin errors++; $display("FAIL basic_num got %h exp 1234", nums); end
      checks++; if (ens !== 4'b1111) begin errors++; $display("FAIL basic_en got %b exp 1111", ens); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ovf); end
      @(posedge CLK);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
   endtask

   task automatic test_lz_blank();
      int n;
      do_start(14'd7);
      wait_done(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL lz7_latency got %0d exp 15", n); end
      checks++; if (nums !== 16'h0007) begin errors++; $display("FAIL lz7_num got %h exp 0007", nums); end
      checks++; if (ens !== 4'b0001) begin errors++; $display("FAIL lz7_en got %b exp 0001", ens); end
      checks++; if (ens_b !== 4'b1111) begin errors++; $display("FAIL lz7_en_nb got %b exp 1111", ens_b); end
      do_start(14'd0);
      wait_done(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL lz0_latency got %0d exp 15", n); end
      checks++; if (nums !== 16'h0000) begin errors++; $display("FAIL lz0_num got %h exp 0000", nums); end
      checks++; if (ens !== 4'b0001) begin errors++; $display("FAIL lz0_en got %b exp 0001", ens); end
      do_start(14'd9999);
      wait_done(n);
      checks++; if (nums !== 16'h9999) begin errors++; $display("FAIL lz9999_num got %h exp 9999", nums); end
      checks++; if (ens !== 4'b1111) begin errors++; $display("FAIL lz9999_en got %b exp 1111", ens); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL lz9999_ovf got %b exp 0", ovf); end
      do_start(14'd305);
      wait_done(n);
      checks++; if (nums !== 16'h0305) begin errors++; $display("FAIL lz305_num got %h exp 0305", nums); end
      checks++; if (ens !== 4'b0111) begin errors++; $display("FAIL lz305_en got %b exp 0111", ens); end
   endtask

   task automatic test_overflow();
      int n;
      do_start(14'd10000);
      wait_done(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL ovf_latency got %0d exp 15", n); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ovf); end
      checks++; if (nums !== 16'hE000) begin errors++; $display("FAIL ovf_num got %h exp e000", nums); end
      checks++; if (ens !== 4'b1000) begin errors++; $display("FAIL ovf_en got %b exp 1000", ens); end
      checks++; if (ens_b !== 4'b1000 || nums_b !== 16'hE000) begin errors++; $display("FAIL ovf_nb got %h/%b exp e000/1000", nums_b, ens_b); end
      do_start(14'd42);
      wait_done(n);
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
      checks++; if (nums !== 16'h0042) begin errors++; $display("FAIL ovf42_num got %h exp 0042", nums); end
      checks++; if (ens !== 4'b0011) begin errors++; $display("FAIL ovf42_en got %b exp 0011", ens); end
      do_start(14'd16383);
      wait_done(n);
      checks++; if (ovf !== 1'b1 || nums !== 16'hE000) begin errors++; $display("FAIL ovf_max got %b/%h exp 1/e000", ovf, nums); end
   endtask

   task automatic test_ignore_start();
      int dones, first;
      dones = 0;
      first = -1;
      do_start(14'd5678);
      repeat (4) @(posedge CLK);
      @(negedge CLK);
      START = 1'b1;
      VALUE = 14'd1111;
      @(posedge CLK);
      #1;
      START = 1'b0;
      for (int i = 6; i <= 45; i++) begin
         @(posedge CLK);
         #1;
         if (done) begin
            dones++;
            if (first < 0) first = i;
         end
      end
      checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", dones); end
      checks++; if (first !== 15) begin errors++; $display("FAIL ignore_latency got %0d exp 15", first); end
      checks++; if (nums !== 16'h5678) begin errors++; $display("FAIL ignore_num got %h exp 5678", nums); end
   endtask

   task automatic test_abort();
      int dones, n;
      dones = 0;
      do_start(14'd1234);
      repeat (7) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
      checks++; if (nums !== 16'h0000 || ens !== 4'b0000) begin errors++; $display("FAIL abort_outputs got %h/%b exp 0000/0000", nums, ens); end
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK);
         #1;
         if (done) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", dones); end
      checks++; if (nums !== 16'h0000) begin errors++; $display("FAIL abort_no_update got %h exp 0000", nums); end
      do_start(14'd8021);
      wait_done(n);
      checks++; if (n !== 15) begin errors++; $display("FAIL abort_restart_latency got %0d exp 15", n); end
      checks++; if (nums !== 16'h8021 || ens !== 4'b1111) begin errors++; $display("FAIL abort_restart got %h/%b exp 8021/1111", nums, ens); end
   endtask

   task automatic test_back_to_back();
      int dones, t0, t1;
      dones = 0;
      t0 = -1;
      t1 = -1;
      @(negedge CLK);
      START = 1'b1;
      VALUE = 14'd0;
      @(posedge CLK);
      #1;
      VALUE = 14'd100;
      for (int i = 1; i <= 40; i++) begin
         @(posedge CLK);
         #1;
         if (done) begin
            dones++;
            if (dones == 1) begin
               t0 = i;
               checks++; if (nums !== 16'h0000 || ens !== 4'b0001) begin errors++; $display("FAIL b2b_first got %h/%b exp 0000/0001", nums, ens); end
               checks++; if (nums_b !== 16'h0000 || ens_b !== 4'b1111) begin errors++; $display("FAIL b2b_first_nb got %h/%b exp 0000/1111", nums_b, ens_b); end
            end else if (dones == 2) begin
               t1 = i;
               checks++; if (nums !== 16'h0100 || ens !== 4'b0111) begin errors++; $display("FAIL b2b_second got %h/%b exp 0100/0111", nums, ens); end
               checks++; if (nums_b !== 16'h0100 || ens_b !== 4'b1111) begin errors++; $display("FAIL b2b_second_nb got %h/%b exp 0100/1111", nums_b, ens_b); end
            end
         end
      end
      checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
      checks++; if (t0 !== 15 || t1 !== 31) begin errors++; $display("FAIL b2b_spacing got %0d,%0d exp 15,31", t0, t1); end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lz_blank();
      test_overflow();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
